// File: rtl/speed_selector.sv
// Button front-end for the servo PWM controller: synchronise, debounce and edge-detect up/down, keep a saturating speed.
// Optional auto-repeat on held buttons is enabled by defining AUTO_REPEAT_EN.
module speed_selector #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_SPEED       = 7,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    output logic [2:0] speed,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       at_min,
    output logic       at_max
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    SPEED_MAX = 3'(MAX_SPEED);

    if (DEBOUNCE_CYCLES < 2 || MAX_SPEED < 1 || MAX_SPEED > 7 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("speed_selector: parameter out of range");
    end

    // Bit 0 carries the up button, bit 1 the down button throughout.
    logic [1:0]    btn;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    pulse;
    logic [1:0]    rep;
    logic [CW-1:0] cnt [2];

    assign btn = {down, up};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            pulse    <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_d <= stable;
            pulse    <= (stable & ~stable_d) | rep;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    // rcnt counts edges since the debounced level rose; rphase selects
    // the first-repeat delay versus the steady repeat period.
    logic [RW-1:0] rcnt [2];
    logic [1:0]    rphase;
    logic [1:0]    fire;

    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            fire[i] = stable[i] &&
                      (rcnt[i] == (rphase[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rphase <= '0;
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!stable[i]) begin
                    rcnt[i]   <= '0;
                    rphase[i] <= 1'b0;
                end else if (fire[i]) begin
                    rcnt[i]   <= RW'(1);
                    rphase[i] <= 1'b1;
                end else begin
                    rcnt[i] <= rcnt[i] + RW'(1);
                end
            end
        end
    end

    assign rep = fire;
`else
    assign rep = '0;
`endif

    assign up_pulse   = pulse[0];
    assign down_pulse = pulse[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            speed <= '0;
        end else if (pulse == 2'b01) begin
            speed <= (speed == SPEED_MAX) ? speed : speed + 3'd1;
        end else if (pulse == 2'b10) begin
            speed <= (speed == 3'd0) ? speed : speed - 3'd1;
        end
    end

    assign at_min = (speed == 3'd0);
    assign at_max = (speed == SPEED_MAX);

endmodule

// File: doc/speed_selector.md
Name: speed_selector

Overview:
- Front-end stage for the servo PWM controller.
- Conditions the raw `up`/`down` push-buttons: 2-FF synchroniser, then per-button debounce, then press-edge detection.
- Maintains the saturating 3-bit `speed` word consumed by the PWM `control` stage.
- Replaces the raw-button `posedge` clocking of `speed`: all logic runs on `clk`.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles a synchronised level must hold before being accepted (20 ms at 50 MHz); minimum 2.
- MAX_SPEED, 7, upper saturation value of `speed`; range 1..7.
- REPEAT_DELAY, 25000000, cycles a button must be held before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 12500000, cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- up  input  1  raw, asynchronous, bouncing button; press = 1; increments `speed`.
- down  input  1  raw, asynchronous, bouncing button; press = 1; decrements `speed`.
- speed  output  3  current speed selection, registered.
- up_pulse  output  1  one-cycle strobe per accepted `up` step.
- down_pulse  output  1  one-cycle strobe per accepted `down` step.
- at_min  output  1  high when speed == 0.
- at_max  output  1  high when speed == MAX_SPEED.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values (rst high at a clk edge): speed=0, up_pulse=0, down_pulse=0, at_min=1, at_max=0, sync flops=0, debounced levels=0, debounce/repeat counters=0.
- Reset mid-operation: all in-flight debounce progress is discarded. A button still held after reset must be re-debounced from scratch and then produces a fresh press.
- Synchroniser: two flops per button (s1, s2).
- Debounce, per button, counter width $clog2(DEBOUNCE_CYCLES):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Any bounce back to the stable level restarts the count.
- Press detect: pulse register <= stable & ~stable_d.
  - Exactly one cycle per press.
  - No pulse on release.
- Latency, with the input high before edge 1:
  - stable rises at edge DEBOUNCE_CYCLES+2.
  - up_pulse is high for the cycle after edge DEBOUNCE_CYCLES+3.
  - speed updates at edge DEBOUNCE_CYCLES+4.
- Speed update on each edge:
  - up_pulse & ~down_pulse: speed <= (speed == MAX_SPEED) ? speed : speed+1.
  - down_pulse & ~up_pulse: speed <= (speed == 0) ? 0 : speed-1.
  - Both pulses high, or neither: speed holds.
- Saturation: no wrap-around in either direction.
- Flags: at_min and at_max are combinational decodes of the `speed` register, so they change in the same cycle as `speed`.
- Pulses are still emitted at saturation; `speed` simply does not move.
- Held button without AUTO_REPEAT_EN: exactly one step per press.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Per-button repeat counter runs while the debounced level is 1.
  - First extra pulse fires REPEAT_DELAY cycles after the initial press pulse.
  - Further pulses fire every REPEAT_PERIOD cycles while held.
  - Release, or rst, clears the counter.
  - Simultaneous pulse and saturation rules apply unchanged.
- Undefined: repeat counters and REPEAT_* logic are absent; one step per press.

Test Plan:
- Reset/latency, DEBOUNCE_CYCLES=4: rst for 2 cycles, then up=1 held.
  - Expect at_min=1 after reset.
  - up_pulse high exactly one cycle after edge 7.
  - speed 0->1 at edge 8; no further change while held or on release.
- Bounce rejection, DEBOUNCE_CYCLES=4: up toggles 1,0,1,0 every cycle for 10 cycles, then stays 0.
  - Expect no up_pulse; speed unchanged.
- Saturation, MAX_SPEED=7: 9 clean up presses from 0.
  - Expect speed=7 and at_max=1 after the 7th press; presses 8 and 9 leave speed=7.
  - Then 9 down presses: speed=0, at_min=1, no wrap to 7.
- Simultaneous events: up and down released from reset identically and held.
  - Expect both pulses in the same cycle; speed unchanged at 0.
- Reset mid-debounce, DEBOUNCE_CYCLES=4: down=1 while speed=3; assert rst at edge 4 for one cycle; keep down held.
  - Expect speed=0 after reset.
  - Fresh down_pulse after a full re-debounce; speed stays 0 (floor).
- AUTO_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold up for 60 cycles.
  - Expect pulses at press, +20, +30, +40, +50 cycles; speed=5.
  - No pulses after release.
